mem_block_mover: RTL

- Initiator-side companion to the 32x8 data memory: drives address, write data, write enable and read enable, and consumes the memory's combinational read data.
- On a start pulse, copies a block of `len` bytes from a source address to a destination address, one word at a time.
- Sits beside the datapath and is muxed onto the memory port while `busy` is high. Used for array setup and copy-out in test programs.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_block_mover_if.sv | 20 ++
 rtl/mem_block_mover.sv | 105 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared widths and FSM state type for the block mover and its memory port.
package mem_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 8;
    localparam int LEN_W     = 6;
    localparam int MEM_DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_block_mover_if.sv
// Memory port between an initiator (master) and the 32x8 data memory (slave).
interface mem_block_mover_if;

    logic [mem_pkg::ADDR_W-1:0] mem_adr;
    logic [mem_pkg::DATA_W-1:0] mem_data;
    logic                       mem_wen;
    logic                       mem_read;
    logic [mem_pkg::DATA_W-1:0] mem_rdata;

    modport master (
        output mem_adr, mem_data, mem_wen, mem_read,
        input  mem_rdata
    );

    modport slave (
        input  mem_adr, mem_data, mem_wen, mem_read,
        output mem_rdata
    );

endinterface

// File: rtl/mem_block_mover.sv
// Copies len bytes from src_adr to dst_adr, one read/write pair per word.
// Optional running byte sum of the copied data when MBM_SUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; memory port quiet
// READ  | drive src+index, capture read data into buffer
// WRITE | write buffer to dst+index, advance index
// DONE  | one-cycle completion pulse, busy still high
module mem_block_mover
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_adr,
    input  logic [ADDR_W-1:0] dst_adr,
    input  logic [LEN_W-1:0]  len,
    mem_block_mover_if.master mem,
    output logic              busy,
    output logic              done
`ifdef MBM_SUM_EN
    ,
    output logic [DATA_W-1:0] sum
`endif
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  len_q, idx_q;
    logic [DATA_W-1:0] buf_q;
`ifdef MBM_SUM_EN
    logic [DATA_W-1:0] sum_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            idx_q <= '0;
            buf_q <= '0;
`ifdef MBM_SUM_EN
            sum_q <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q <= src_adr;
                        dst_q <= dst_adr;
                        len_q <= len;
                        idx_q <= '0;
`ifdef MBM_SUM_EN
                        sum_q <= '0;
`endif
                    end
                end
                READ: begin
                    buf_q <= mem.mem_rdata;
`ifdef MBM_SUM_EN
                    sum_q <= sum_q + mem.mem_rdata;
`endif
                end
                WRITE:   idx_q <= idx_q + LEN_W'(1);
                default: ;
            endcase
        end
    end

    // Port outputs decode straight from state so an async reset silences them at once.
    always_comb begin
        state_nxt    = state;
        mem.mem_adr  = '0;
        mem.mem_data = '0;
        mem.mem_wen  = 1'b0;
        mem.mem_read = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (len == '0) ? DONE : READ;
            end
            READ: begin
                mem.mem_read = 1'b1;
                mem.mem_adr  = src_q + idx_q[ADDR_W-1:0];
                state_nxt    = WRITE;
            end
            WRITE: begin
                mem.mem_wen  = 1'b1;
                mem.mem_adr  = dst_q + idx_q[ADDR_W-1:0];
                mem.mem_data = buf_q;
                state_nxt    = (idx_q == len_q - LEN_W'(1)) ? DONE : READ;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
`ifdef MBM_SUM_EN
    assign sum  = sum_q;
`endif

endmodule
